t_mod_counter: RTL and testbench

//   Synchronous modulo-N up/down counter built from toggle cells: next state is computed

---
 rtl/ddhw_cnt_pkg.sv | 15 +
 rtl/t_cell.sv | 18 +
 rtl/t_mod_counter.sv | 102 ++++++++++
 tb/tb_t_mod_counter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ddhw_cnt_pkg.sv
// Shared constants and helpers for the modulo-N toggle counter.
// Holds direction encodings and the load range test.
package ddhw_cnt_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  function automatic logic in_range(
    input logic [31:0] val,
    input logic [31:0] mod
  );
    return val < mod;
  endfunction

endpackage

// File: rtl/t_cell.sv
// Single-bit toggle register, async active-low reset.
// Ports: Q state out, T toggle enable, Clk, Rst.
module t_cell (
  output logic Q,
  input  logic T,
  input  logic Clk,
  input  logic Rst
);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Q <= 1'b0;
    end else if (T) begin
      Q <= ~Q;
    end
  end

endmodule

// File: rtl/t_mod_counter.sv
// Modulo-N up/down counter built from t_cell toggle stages.
// Ports: Clk, Rst (async low), En, Up, Load, D -> Q, Tc, Ovf.
// Define CNT_SATURATE_EN to hold at the ends instead of wrapping.
module t_mod_counter
  import ddhw_cnt_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Tc,
  output logic             Ovf
);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("t_mod_counter: WIDTH must be 2..16");
  end
  if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_mod
    $error("t_mod_counter: MODULUS must be 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] t;
  logic             at_max;
  logic             at_min;
  logic             over;
  logic             ovf_set;

  assign at_max = (Q == MAX);
  assign at_min = (Q == '0);
  assign over   = (Q > MAX);

  always_comb begin
    nxt     = Q;
    ovf_set = 1'b0;
    if (Load) begin
      nxt = in_range(32'(D), 32'(MODULUS)) ? D : '0;
    end else if (En) begin
      if (over) begin
        // forced out-of-range state recovers to zero
        nxt = '0;
      end else if (Up == CNT_UP) begin
        if (at_max) begin
`ifdef CNT_SATURATE_EN
          nxt = Q;
`else
          nxt = '0;
`endif
          ovf_set = 1'b1;
        end else begin
          nxt = Q + WIDTH'(1);
        end
      end else begin
        if (at_min) begin
`ifdef CNT_SATURATE_EN
          nxt = Q;
`else
          nxt = MAX;
`endif
          ovf_set = 1'b1;
        end else begin
          nxt = Q - WIDTH'(1);
        end
      end
    end
  end

  // each cell flips exactly the bits that differ
  assign t = Q ^ nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_cell u_cell (
      .Q   (Q[i]),
      .T   (t[i]),
      .Clk (Clk),
      .Rst (Rst)
    );
  end

  assign Tc = En & ~Load &
              (((Up == CNT_UP) & at_max) |
               ((Up == CNT_DN) & at_min));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Ovf <= 1'b0;
    end else if (Load) begin
      Ovf <= 1'b0;
    end else if (ovf_set) begin
      Ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_t_mod_counter.sv
// Self-checking bench for t_mod_counter with a behavioural model.
// Covers directed cases, random stimulus and a two-stage cascade.
module tb_t_mod_counter;

  localparam int W = 4;
  localparam int M = 10;
`ifdef CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Rst;
  logic         En;
  logic         Up;
  logic         Load;
  logic [W-1:0] D;
  logic [W-1:0] Q;
  logic         Tc;
  logic         Ovf;

  logic         c_en;
  logic [W-1:0] lo_q;
  logic [W-1:0] hi_q;
  logic         lo_tc;
  logic         hi_tc;
  logic         lo_ovf;
  logic         hi_ovf;

  int nerr = 0;
  int nchk = 0;
  int mq;
  bit movf;
  bit chk_on = 1'b0;

  always #5 Clk = ~Clk;

  t_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .Up(Up), .Load(Load),
    .D(D), .Q(Q), .Tc(Tc), .Ovf(Ovf)
  );

  t_mod_counter #(.WIDTH(W), .MODULUS(M)) u_lo (
    .Clk(Clk), .Rst(Rst), .En(c_en), .Up(1'b1), .Load(1'b0),
    .D(4'd0), .Q(lo_q), .Tc(lo_tc), .Ovf(lo_ovf)
  );

  t_mod_counter #(.WIDTH(W), .MODULUS(M)) u_hi (
    .Clk(Clk), .Rst(Rst), .En(lo_tc), .Up(1'b1), .Load(1'b0),
    .D(4'd0), .Q(hi_q), .Tc(hi_tc), .Ovf(hi_ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // reference: step the count with plain integer arithmetic
  always @(posedge Clk or negedge Rst) begin
    int raw;
    if (!Rst) begin
      mq   = 0;
      movf = 1'b0;
    end else if (Load) begin
      mq   = (int'(D) < M) ? int'(D) : 0;
      movf = 1'b0;
    end else if (En) begin
      raw = Up ? mq + 1 : mq - 1;
      if (raw < 0 || raw >= M) begin
        movf = 1'b1;
        if (!SAT) mq = (raw + M) % M;
      end else begin
        mq = raw;
      end
    end
  end

  always @(negedge Clk) begin
    bit etc;
    if (chk_on) begin
      etc = En && !Load && (Up ? (mq + 1 == M) : (mq == 0));
      chk("model_q", Q, mq);
      chk("model_ovf", Ovf, movf);
      chk("model_tc", Tc, etc);
    end
  end

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
    #1;
  endtask

  initial begin
    int t3q [3];
    int lo_e;
    int hi_e;
    Rst = 1'b0; En = 1'b1; Up = 1'b1; Load = 1'b0;
    D = '0; c_en = 1'b0;
    @(negedge Clk);
    #1;

    // 1: reset holds through edges, first edge after release counts
    chk("rst_q", Q, 0);
    chk("rst_ovf", Ovf, 0);
    step();
    chk("rst_q_e1", Q, 0);
    step();
    chk("rst_q_e2", Q, 0);
    chk("rst_ovf_e2", Ovf, 0);
    Rst = 1'b1;
    step();
    chk("rel_q", Q, 1);
    chk_on = 1'b1;

    // 2: count up through the wrap
    Load = 1'b1; D = 4'd0;
    step();
    Load = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      chk("up_tc", Tc, (k == 10));
      step();
      if (SAT) chk("up_q", Q, (k < 9) ? k : 9);
      else     chk("up_q", Q, k % 10);
      chk("up_ovf", Ovf, (k >= 10));
    end

    // 3: count down from 1
    Load = 1'b1; D = 4'd1;
    step();
    Load = 1'b0; Up = 1'b0;
    if (SAT) t3q = '{0, 0, 0};
    else     t3q = '{0, 9, 8};
    for (int k = 0; k < 3; k++) begin
      step();
      chk("dn_q", Q, t3q[k]);
      chk("dn_ovf", Ovf, (k >= 1));
    end

    // 4: load wins over enable, out-of-range load clamps to 0
    Load = 1'b1; En = 1'b1; Up = 1'b1; D = 4'd7;
    step();
    chk("ld7_q", Q, 7);
    chk("ld7_ovf", Ovf, 0);
    D = 4'd12;
    step();
    chk("ld12_q", Q, 0);

    // 5: hold with En low while Up and D wiggle
    D = 4'd5;
    step();
    Load = 1'b0; En = 1'b0;
    for (int k = 0; k < 5; k++) begin
      Up = 1'($urandom);
      D  = 4'($urandom);
      #1;
      chk("hold_tc", Tc, 0);
      step();
      chk("hold_q", Q, 5);
    end

    // random traffic with occasional async reset between edges
    for (int k = 0; k < 800; k++) begin
      Load = ($urandom_range(0, 9) == 0);
      En   = ($urandom_range(0, 3) != 0);
      Up   = 1'($urandom);
      D    = 4'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #1 Rst = 1'b0;
        #1 Rst = 1'b1;
      end
      step();
    end

    // 6: two-stage decimal cascade
    Load = 1'b0; En = 1'b0;
    #1 Rst = 1'b0;
    #1 Rst = 1'b1;
    c_en = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (SAT) begin
        lo_e = (k < 9) ? k : 9;
        hi_e = (k <= 9) ? 0 : ((k - 9 < 9) ? k - 9 : 9);
      end else begin
        lo_e = k % 10;
        hi_e = (k % 100) / 10;
      end
      chk("casc", hi_q * 10 + lo_q, hi_e * 10 + lo_e);
    end
    c_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
